// File: rtl/lcd_bus_pkg.sv
// Shared opcode masks, fill character, FSM state and debug struct for the LCD bus responder.
// Also provides the instruction decoder used by lcd_bus_responder.
package lcd_bus_pkg;

  localparam logic [7:0] OP_SETDD = 8'h80;
  localparam logic [7:0] OP_DISP  = 8'h08;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_HOME  = 8'h02;
  localparam logic [7:0] OP_CLR   = 8'h01;
  localparam logic [7:0] SPACE    = 8'h20;

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} lcd_state_e;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_CLR, CMD_HOME, CMD_ENTRY, CMD_DISP, CMD_SETDD
  } lcd_cmd_e;

  typedef struct packed {
    lcd_state_e state;
    logic       id;
    logic       shift;
  } lcd_dbg_t;

  // Highest set bit selects the instruction; bits 6..4 belong to codes we do not model.
  function automatic lcd_cmd_e decode_cmd(input logic [7:0] db);
    if ((db & OP_SETDD) != 8'h00) return CMD_SETDD;
    if (db[6:4] != 3'b000)        return CMD_NONE;
    if ((db & OP_DISP) != 8'h00)  return CMD_DISP;
    if ((db & OP_ENTRY) != 8'h00) return CMD_ENTRY;
    if ((db & OP_HOME) != 8'h00)  return CMD_HOME;
    if ((db & OP_CLR) != 8'h00)   return CMD_CLR;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// Parallel LCD bus as seen between a write driver (master) and the responder (slave).
// A transfer is the en strobe: fields are sampled while en is high and the command is taken on its falling edge.
interface lcd_bus_responder_if;
  logic       lcd_rst;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db_i;
  logic [7:0] lcd_db_o;
  logic       lcd_db_oe;

  modport master (
    output lcd_rst, lcd_en, lcd_rs, lcd_rw, lcd_db_i,
    input  lcd_db_o, lcd_db_oe
  );

  modport slave (
    input  lcd_rst, lcd_en, lcd_rs, lcd_rw, lcd_db_i,
    output lcd_db_o, lcd_db_oe
  );
endinterface

// File: rtl/lcd_bus_sync.sv
// Two-flop synchroniser for en/rs/rw/db plus en falling-edge detect.
// cmd_* carry the synchronised fields from the cycle before the edge.
module lcd_bus_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [7:0] db_i,
  output logic       en_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic       cmd_rs_o,
  output logic       cmd_rw_o,
  output logic [7:0] cmd_db_o,
  output logic       fall_o
);

  logic [10:0] s1_q, s2_q, cmd_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      cmd_q <= '0;
    end else begin
      s1_q  <= {en_i, rs_i, rw_i, db_i};
      s2_q  <= s1_q;
      cmd_q <= s2_q;
    end
  end

  assign en_o     = s2_q[10];
  assign rs_o     = s2_q[9];
  assign rw_o     = s2_q[8];
  assign cmd_rs_o = cmd_q[9];
  assign cmd_rw_o = cmd_q[8];
  assign cmd_db_o = cmd_q[7:0];
  assign fall_o   = cmd_q[10] & ~s2_q[10];

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style bus target: decodes instructions, stores DDRAM, models busy time.
// Define LCD_RESP_READ_EN to enable status/data read cycles; otherwise the bus is never driven.
module lcd_bus_responder
  import lcd_bus_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int AW           = 5,
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic                clk,
  input  logic                rst_n,
  lcd_bus_responder_if.slave  bus,
  input  logic [AW-1:0]       dbg_addr,
  output logic [7:0]          dbg_data,
  output logic [AW-1:0]       ac,
  output logic                busy,
  output logic                disp_on,
  output logic                cur_on,
  output logic                blink_on,
  output logic                wr_strobe,
  output logic                cmd_drop,
  output lcd_dbg_t            dbg_state
);

  localparam int CW = $clog2(CLEAR_CYCLES);

  logic       en_s, rs_s, rw_s, cmd_rs, cmd_rw, fall;
  logic [7:0] cmd_db;

  lcd_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (bus.lcd_en),
    .rs_i     (bus.lcd_rs),
    .rw_i     (bus.lcd_rw),
    .db_i     (bus.lcd_db_i),
    .en_o     (en_s),
    .rs_o     (rs_s),
    .rw_o     (rw_s),
    .cmd_rs_o (cmd_rs),
    .cmd_rw_o (cmd_rw),
    .cmd_db_o (cmd_db),
    .fall_o   (fall)
  );

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   fill_q, fill_d;
  logic [AW-1:0] ac_q, ac_d;
  logic          id_q, id_d, sh_q, sh_d;
  logic          disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic          wr_strobe_q, wr_strobe_d, cmd_drop_q, cmd_drop_d;

  logic [7:0]    mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  function automatic logic [AW-1:0] ac_step(input logic [AW-1:0] a, input logic inc);
    if (inc) return (a == AW'(DEPTH-1)) ? '0 : a + AW'(1);
    return (a == '0) ? AW'(DEPTH-1) : a - AW'(1);
  endfunction

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    ac_d        = ac_q;
    id_d        = id_q;
    sh_d        = sh_q;
    disp_d      = disp_q;
    cur_d       = cur_q;
    blink_d     = blink_q;
    wr_strobe_d = 1'b0;
    cmd_drop_d  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = ac_q;
    mem_wdata   = cmd_db;

    case (state_q)
      EXEC: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      CLEAR: begin
        // Fill one entry per cycle; the rest of the period is pure busy time.
        if (fill_q != (AW+1)'(DEPTH)) begin
          mem_we    = 1'b1;
          mem_addr  = fill_q[AW-1:0];
          mem_wdata = SPACE;
          fill_d    = fill_q + (AW+1)'(1);
        end
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: ;
    endcase

    if (fall) begin
      if (cmd_rw) begin
`ifdef LCD_RESP_READ_EN
        if (cmd_rs) ac_d = ac_step(ac_q, id_q);
`endif
      end else if (busy) begin
        cmd_drop_d = 1'b1;
      end else begin
        state_d = EXEC;
        cnt_d   = CW'(BUSY_CYCLES-1);
        if (cmd_rs) begin
          mem_we      = 1'b1;
          ac_d        = ac_step(ac_q, id_q);
          wr_strobe_d = 1'b1;
        end else begin
          case (decode_cmd(cmd_db))
            CMD_SETDD: ac_d = (32'(cmd_db[AW-1:0]) >= DEPTH) ?
                              AW'(32'(cmd_db[AW-1:0]) - DEPTH) : cmd_db[AW-1:0];
            CMD_DISP: begin
              disp_d  = cmd_db[2];
              cur_d   = cmd_db[1];
              blink_d = cmd_db[0];
            end
            CMD_ENTRY: begin
              id_d = cmd_db[1];
              sh_d = cmd_db[0];
            end
            CMD_HOME: ac_d = '0;
            CMD_CLR: begin
              state_d = CLEAR;
              cnt_d   = CW'(CLEAR_CYCLES-1);
              fill_d  = '0;
              ac_d    = '0;
              id_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n || !bus.lcd_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_q      <= '0;
      ac_q        <= '0;
      id_q        <= 1'b1;
      sh_q        <= 1'b0;
      disp_q      <= 1'b0;
      cur_q       <= 1'b0;
      blink_q     <= 1'b0;
      wr_strobe_q <= 1'b0;
      cmd_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      sh_q        <= sh_d;
      disp_q      <= disp_d;
      cur_q       <= cur_d;
      blink_q     <= blink_d;
      wr_strobe_q <= wr_strobe_d;
      cmd_drop_q  <= cmd_drop_d;
    end
  end

  // No reset on DDRAM: contents survive lcd_rst and an aborted clear.
  always_ff @(posedge clk) begin
    if (mem_we && bus.lcd_rst) mem[mem_addr] <= mem_wdata;
  end

  assign dbg_data  = mem[dbg_addr];
  assign ac        = ac_q;
  assign disp_on   = disp_q;
  assign cur_on    = cur_q;
  assign blink_on  = blink_q;
  assign wr_strobe = wr_strobe_q;
  assign cmd_drop  = cmd_drop_q;
  assign dbg_state = '{state: state_q, id: id_q, shift: sh_q};

`ifdef LCD_RESP_READ_EN
  assign bus.lcd_db_oe = en_s & rw_s;
  assign bus.lcd_db_o  = rs_s ? mem[ac_q] : {busy, 7'(ac_q)};
`else
  logic unused_live;
  assign unused_live   = ^{en_s, rs_s, rw_s};
  assign bus.lcd_db_oe = 1'b0;
  assign bus.lcd_db_o  = '0;
`endif

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder; accepted data writes queue the expected
// post-write address counter, popped when wr_strobe is seen.
module tb_lcd_bus_responder;
  import lcd_bus_pkg::*;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_data;
  logic [AW-1:0] ac;
  logic          busy, disp_on, cur_on, blink_on, wr_strobe, cmd_drop;
  lcd_dbg_t      dbg_state;

  lcd_bus_responder_if bus();

  lcd_bus_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .ac        (ac),
    .busy      (busy),
    .disp_on   (disp_on),
    .cur_on    (cur_on),
    .blink_on  (blink_on),
    .wr_strobe (wr_strobe),
    .cmd_drop  (cmd_drop),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  int strobe_cnt = 0;
  int drop_cnt = 0;
  logic [AW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: each write strobe must match the next queued ac value
  always @(negedge clk) begin
    if (cmd_drop === 1'b1) drop_cnt++;
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      if (exp_q.size() == 0) check_eq("wr_q_size", exp_q.size(), 1);
      else check_eq("ac_after_wr", ac, exp_q.pop_front());
    end
  end

  // drivers
  task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_db_i = d; bus.lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    bus.lcd_en = 1'b0;
    repeat (4) @(negedge clk);
    bus.lcd_rw = 1'b0;
  endtask

  task automatic data_wr(input logic [7:0] d, input logic [AW-1:0] ac_after);
    exp_q.push_back(ac_after);
    bus_xfer(1'b1, 1'b0, d);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check_eq("busy_timeout", busy, 0);
  endtask

  task automatic peek(input string tag, input logic [AW-1:0] a, input logic [7:0] e);
    dbg_addr = a;
    #1;
    check_eq(tag, dbg_data, e);
  endtask

  int s0, d0;

  initial begin
    rst_n = 1'b1;
    bus.lcd_rst = 1'b1; bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0;
    bus.lcd_rw = 1'b0; bus.lcd_db_i = 8'h00; dbg_addr = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ac", ac, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_disp", disp_on, 0);
    check_eq("rst_strobe", wr_strobe, 0);
    check_eq("rst_drop", cmd_drop, 0);
    check_eq("rst_oe", bus.lcd_db_oe, 0);
    check_eq("rst_state", dbg_state.state, IDLE);
    check_eq("rst_id", dbg_state.id, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // 1: function set, display on, entry mode, then 'A','B'
    s0 = strobe_cnt;
    bus_xfer(1'b0, 1'b0, 8'h38);
    check_eq("busy_after_cmd", busy, 1);
    wait_idle(100);
    bus_xfer(1'b0, 1'b0, 8'h0C);
    wait_idle(100);
    bus_xfer(1'b0, 1'b0, 8'h06);
    wait_idle(100);
    data_wr(8'h41, 5'd1);
    wait_idle(100);
    data_wr(8'h42, 5'd2);
    wait_idle(100);
    peek("t1_dd0", 5'd0, 8'h41);
    peek("t1_dd1", 5'd1, 8'h42);
    check_eq("t1_ac", ac, 2);
    check_eq("t1_disp", disp_on, 1);
    check_eq("t1_cur", cur_on, 0);
    check_eq("t1_blink", blink_on, 0);
    check_eq("t1_strobes", strobe_cnt - s0, 2);

    // 2: data write inside the busy window is dropped
    s0 = strobe_cnt; d0 = drop_cnt;
    bus_xfer(1'b0, 1'b0, 8'h0E);
    bus_xfer(1'b1, 1'b0, 8'h5A);
    check_eq("t2_drops", drop_cnt - d0, 1);
    check_eq("t2_strobes", strobe_cnt - s0, 0);
    check_eq("t2_ac", ac, 2);
    check_eq("t2_cur", cur_on, 1);
    peek("t2_dd1", 5'd1, 8'h42);
    wait_idle(100);

`ifndef LCD_RESP_READ_EN
    // read cycles are ignored without read support, even while busy
    d0 = drop_cnt;
    bus_xfer(1'b0, 1'b0, 8'h0C);
    @(negedge clk);
    bus.lcd_rs = 1'b1; bus.lcd_rw = 1'b1; bus.lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("nord_oe", bus.lcd_db_oe, 0);
    check_eq("nord_dbo", bus.lcd_db_o, 0);
    bus.lcd_en = 1'b0;
    repeat (4) @(negedge clk);
    bus.lcd_rw = 1'b0;
    check_eq("nord_ac", ac, 2);
    check_eq("nord_drop", drop_cnt - d0, 0);
    wait_idle(100);
`endif

    // 3: address wrap in both directions
    bus_xfer(1'b0, 1'b0, 8'h9F);
    check_eq("t3_setdd", ac, 31);
    wait_idle(100);
    data_wr(8'h55, 5'd0);
    wait_idle(100);
    peek("t3_dd31", 5'd31, 8'h55);
    check_eq("t3_ac_wrap", ac, 0);
    bus_xfer(1'b0, 1'b0, 8'h04);
    wait_idle(100);
    data_wr(8'h66, 5'd31);
    wait_idle(100);
    peek("t3_dd0", 5'd0, 8'h66);
    check_eq("t3_ac_dec", ac, 31);

    // 6: bus reset keeps DDRAM, restores I/D
    @(negedge clk);
    bus.lcd_rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("t6_ac", ac, 0);
    check_eq("t6_disp", disp_on, 0);
    bus.lcd_rst = 1'b1;
    @(negedge clk);
    peek("t6_dd0", 5'd0, 8'h66);
    peek("t6_dd31", 5'd31, 8'h55);
    peek("t6_dd1", 5'd1, 8'h42);
    data_wr(8'h77, 5'd1);
    wait_idle(100);
    peek("t6_id_inc", 5'd0, 8'h77);

    // 4: clear display, then abort a second clear with rst_n
    bus_xfer(1'b0, 1'b0, 8'h01);
    repeat (1500) @(negedge clk);
    check_eq("t4_busy_long", busy, 1);
    wait_idle(300);
    for (int i = 0; i < 32; i++) peek("t4_space", 5'(i), 8'h20);
    check_eq("t4_ac", ac, 0);
    data_wr(8'h31, 5'd1);
    wait_idle(100);
    bus_xfer(1'b0, 1'b0, 8'h01);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t4_rst_busy", busy, 0);
    check_eq("t4_rst_ac", ac, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

`ifdef LCD_RESP_READ_EN
    // 5: status read while busy, then data read with ac advance
    bus_xfer(1'b0, 1'b0, 8'h85);
    wait_idle(100);
    data_wr(8'hA5, 5'd6);
    wait_idle(100);
    bus_xfer(1'b0, 1'b0, 8'h85);
    d0 = drop_cnt;
    @(negedge clk);
    bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b1; bus.lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t5_oe", bus.lcd_db_oe, 1);
    check_eq("t5_status", bus.lcd_db_o, 8'h85);
    bus.lcd_en = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t5_ac_status", ac, 5);
    check_eq("t5_no_drop", drop_cnt - d0, 0);
    wait_idle(100);
    bus.lcd_rs = 1'b1; bus.lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t5_data", bus.lcd_db_o, 8'hA5);
    bus.lcd_en = 1'b0;
    repeat (4) @(negedge clk);
    bus.lcd_rw = 1'b0;
    check_eq("t5_ac_adv", ac, 6);
    check_eq("t5_not_busy", busy, 0);
`endif

    check_eq("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
